// File: rtl/vedic_mul_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier.
// Three elastic stages: sign-corrected magnitudes, half-width vertical/crosswise
// partial products, then recombination with optional negation. Each stage loads when it is
// empty or when the stage after it is loading in the same cycle.

module vedic_mul_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH + 1;

  // Stage 1: magnitudes, result sign, tag
  logic               s1_valid_q;
  logic [WIDTH-1:0]   s1_mag_a_q, s1_mag_b_q;
  logic               s1_neg_q;
  logic [TAG_W-1:0]   s1_tag_q;

  // Stage 2: four half-width partial products
  logic               s2_valid_q;
  logic [WIDTH-1:0]   s2_pp_ll_q, s2_pp_hl_q, s2_pp_lh_q, s2_pp_hh_q;
  logic               s2_neg_q;
  logic [TAG_W-1:0]   s2_tag_q;

  // Stage 3: final product
  logic               s3_valid_q;
  logic [2*WIDTH-1:0] s3_p_q;
  logic [TAG_W-1:0]   s3_tag_q;

  logic               s1_load, s2_load, s3_load;

  logic [WIDTH-1:0]   mag_a_d, mag_b_d;
  logic               neg_d;

  logic [H-1:0]       a_lo, a_hi, b_lo, b_hi;
  logic [WIDTH-1:0]   pp_ll_d, pp_hl_d, pp_lh_d, pp_hh_d;

  logic [PW-1:0]      sum_p;
  logic [PW-1:0]      signed_p;
  logic [2*WIDTH-1:0] p_d;

  // Load enables ripple back from the output; out_ready reaches in_ready combinationally.
  always_comb begin
    s3_load = !s3_valid_q || out_ready;
    s2_load = !s2_valid_q || s3_load;
    s1_load = !s1_valid_q || s2_load;
  end

  assign in_ready  = s1_load;
  assign out_valid = s3_valid_q;
  assign out_p     = s3_p_q;
  assign out_tag   = s3_tag_q;
  assign busy      = s1_valid_q | s2_valid_q | s3_valid_q;

  // Sign correction: the magnitude of the most negative value still fits in WIDTH unsigned bits.
  always_comb begin
    mag_a_d = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    mag_b_d = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    neg_d   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
  end

  // Stage 1 register: capture operands only on an accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mag_a_q <= '0;
      s1_mag_b_q <= '0;
      s1_neg_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mag_a_q <= mag_a_d;
        s1_mag_b_q <= mag_b_d;
        s1_neg_q   <= neg_d;
        s1_tag_q   <= in_tag;
      end
    end
  end

  // Vertical (lo*lo, hi*hi) and crosswise (hi*lo, lo*hi) half-width products
  always_comb begin
    a_lo    = s1_mag_a_q[H-1:0];
    a_hi    = s1_mag_a_q[WIDTH-1:H];
    b_lo    = s1_mag_b_q[H-1:0];
    b_hi    = s1_mag_b_q[WIDTH-1:H];
    pp_ll_d = WIDTH'(a_lo) * WIDTH'(b_lo);
    pp_hl_d = WIDTH'(a_hi) * WIDTH'(b_lo);
    pp_lh_d = WIDTH'(a_lo) * WIDTH'(b_hi);
    pp_hh_d = WIDTH'(a_hi) * WIDTH'(b_hi);
  end

  // Stage 2 register: partial products travel with sign and tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_pp_ll_q <= '0;
      s2_pp_hl_q <= '0;
      s2_pp_lh_q <= '0;
      s2_pp_hh_q <= '0;
      s2_neg_q   <= 1'b0;
      s2_tag_q   <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_pp_ll_q <= pp_ll_d;
        s2_pp_hl_q <= pp_hl_d;
        s2_pp_lh_q <= pp_lh_d;
        s2_pp_hh_q <= pp_hh_d;
        s2_neg_q   <= s1_neg_q;
        s2_tag_q   <= s1_tag_q;
      end
    end
  end

  // Recombine at 2*WIDTH+1 bits so the cross-term sum cannot wrap, then apply the sign
  always_comb begin
    sum_p    = (PW'(s2_pp_hh_q) << WIDTH)
             + (PW'(s2_pp_hl_q) << H)
             + (PW'(s2_pp_lh_q) << H)
             + PW'(s2_pp_ll_q);
    signed_p = s2_neg_q ? -sum_p : sum_p;
    p_d      = signed_p[2*WIDTH-1:0];
  end

  // Stage 3 register: holds the product stable while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_p_q     <= '0;
      s3_tag_q   <= '0;
    end else if (s3_load) begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_p_q   <= p_d;
        s3_tag_q <= s2_tag_q;
      end
    end
  end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Bench for vedic_mul_pipe: three instances (WIDTH 4, 8, 16) share handshake controls and are
// checked every cycle against a queue-based model of an in-order, 3-cycle-latency, 3-deep pipe.

module tb_vedic_mul_pipe;

  localparam int unsigned TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid, in_signed, out_ready;
  logic [TAG_W-1:0] in_tag;
  logic [3:0]       a4, b4;
  logic [7:0]       a8, b8;
  logic [15:0]      a16, b16;

  logic             ir4, ir8, ir16, ov4, ov8, ov16, bz4, bz8, bz16;
  logic [7:0]       p4;
  logic [15:0]      p8;
  logic [31:0]      p16;
  logic [TAG_W-1:0] t4, t8, t16;

  vedic_mul_pipe #(.WIDTH(4), .TAG_W(TAG_W)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_signed(in_signed), .in_tag(in_tag), .out_valid(ov4), .out_ready(out_ready),
    .out_p(p4), .out_tag(t4), .busy(bz4)
  );
  vedic_mul_pipe #(.WIDTH(8), .TAG_W(TAG_W)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_signed(in_signed), .in_tag(in_tag), .out_valid(ov8), .out_ready(out_ready),
    .out_p(p8), .out_tag(t8), .busy(bz8)
  );
  vedic_mul_pipe #(.WIDTH(16), .TAG_W(TAG_W)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_signed(in_signed), .in_tag(in_tag), .out_valid(ov16), .out_ready(out_ready),
    .out_p(p16), .out_tag(t16), .busy(bz16)
  );

  typedef struct {
    logic [7:0]       e4;
    logic [15:0]      e8;
    logic [31:0]      e16;
    logic [TAG_W-1:0] tag;
    int               stamp;
    logic             hg4;
    logic [7:0]       g4;
    logic             hg8;
    logic [15:0]      g8;
  } op_t;

  op_t  q[$];
  op_t  ent;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   st_acc = 0;
  logic stall_win = 1'b0, stall_prev = 1'b0;
  logic end_req = 1'b0, end_done = 1'b0;
  logic ov_exp, ir_exp;

  // Constants for directed vectors, picked up by the model when the op is accepted
  logic             cur_hg4 = 1'b0, cur_hg8 = 1'b0;
  logic [7:0]       cur_g4 = '0;
  logic [15:0]      cur_g8 = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Plain integer product, masked to 2*w bits
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic sgn, input int w);
    longint m, sa, sb;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    return 32'((sa * sb) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Mid-cycle monitor: compare DUT against the model, then apply the transfers of the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_out_valid4", 32'(ov4), 32'd0);
      check_eq("rst_out_valid8", 32'(ov8), 32'd0);
      check_eq("rst_out_valid16", 32'(ov16), 32'd0);
      check_eq("rst_out_p4", 32'(p4), 32'd0);
      check_eq("rst_out_p8", 32'(p8), 32'd0);
      check_eq("rst_out_p16", p16, 32'd0);
      check_eq("rst_out_tag", 32'({t4, t8, t16}), 32'd0);
      check_eq("rst_busy", 32'({bz4, bz8, bz16}), 32'd0);
      q.delete();
    end else begin
      ov_exp = 1'b0;
      if (q.size() > 0) ov_exp = (cyc - q[0].stamp) >= 3;
      ir_exp = (q.size() < 3) || out_ready;
      check_eq("in_ready4", 32'(ir4), 32'(ir_exp));
      check_eq("in_ready8", 32'(ir8), 32'(ir_exp));
      check_eq("in_ready16", 32'(ir16), 32'(ir_exp));
      check_eq("busy", 32'({bz4, bz8, bz16}), (q.size() != 0) ? 32'd7 : 32'd0);
      check_eq("out_valid", 32'({ov4, ov8, ov16}), ov_exp ? 32'd7 : 32'd0);
      if (ov_exp) begin
        check_eq("out_p4", 32'(p4), 32'(q[0].e4));
        check_eq("out_p8", 32'(p8), 32'(q[0].e8));
        check_eq("out_p16", p16, q[0].e16);
        check_eq("out_tag4", 32'(t4), 32'(q[0].tag));
        check_eq("out_tag8", 32'(t8), 32'(q[0].tag));
        check_eq("out_tag16", 32'(t16), 32'(q[0].tag));
        if (q[0].hg4) check_eq("gold4", 32'(p4), 32'(q[0].g4));
        if (q[0].hg8) check_eq("gold8", 32'(p8), 32'(q[0].g8));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && ir_exp) begin
        ent.e4    = 8'(ref_mul({12'b0, a4}, {12'b0, b4}, in_signed, 4));
        ent.e8    = 16'(ref_mul({8'b0, a8}, {8'b0, b8}, in_signed, 8));
        ent.e16   = ref_mul(a16, b16, in_signed, 16);
        ent.tag   = in_tag;
        ent.stamp = cyc;
        ent.hg4   = cur_hg4;
        ent.g4    = cur_g4;
        ent.hg8   = cur_hg8;
        ent.g8    = cur_g8;
        q.push_back(ent);
        n_acc++;
      end
      if (stall_win && in_valid && ir4) st_acc++;
      if (stall_prev && !stall_win) check_eq("stall_accepts", 32'(st_acc), 32'd3);
      stall_prev = stall_win;
      if (end_req && !end_done) begin
        check_eq("drain_empty", 32'(q.size()), 32'd0);
        end_done = 1'b1;
      end
    end
    cyc++;
  end

  task automatic randomize_ops();
    a4  = 4'($urandom);
    b4  = 4'($urandom);
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    a16 = 16'($urandom);
    b16 = 16'($urandom);
  endtask

  // Present one op and hold it until accepted; leaves in_valid high for back-to-back streaming
  task automatic send(input logic sgn, input logic [3:0] av, input logic [3:0] bv,
                      input logic [7:0] a8v, input logic [7:0] b8v, input logic [3:0] tag,
                      input logic hg4, input logic [7:0] g4, input logic hg8,
                      input logic [15:0] g8);
    logic acc;
    randomize_ops();
    in_valid  = 1'b1;
    in_signed = sgn;
    a4 = av; b4 = bv; a8 = a8v; b8 = b8v;
    in_tag  = tag;
    cur_hg4 = hg4; cur_g4 = g4; cur_hg8 = hg8; cur_g8 = g8;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = ir4;
      @(posedge clk);
      #1;
    end
    cur_hg4 = 1'b0;
    cur_hg8 = 1'b0;
  endtask

  // Idle cycles with garbage on the operand bus that must be ignored
  task automatic idle(input int n);
    in_valid = 1'b0;
    cur_hg4  = 1'b0;
    cur_hg8  = 1'b0;
    for (int i = 0; i < n; i++) begin
      randomize_ops();
      in_signed = 1'($urandom);
      in_tag    = 4'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b1; in_tag = '0;
    randomize_ops();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // T1: WIDTH=4 unsigned stream
    send(1'b0, 4'd2,  4'd2,  8'($urandom), 8'($urandom), 4'd1, 1'b1, 8'h04, 1'b0, 16'h0);
    send(1'b0, 4'd8,  4'd1,  8'($urandom), 8'($urandom), 4'd2, 1'b1, 8'h08, 1'b0, 16'h0);
    send(1'b0, 4'd2,  4'd10, 8'($urandom), 8'($urandom), 4'd3, 1'b1, 8'h14, 1'b0, 16'h0);
    send(1'b0, 4'd3,  4'd9,  8'($urandom), 8'($urandom), 4'd4, 1'b1, 8'h1B, 1'b0, 16'h0);
    send(1'b0, 4'd5,  4'd9,  8'($urandom), 8'($urandom), 4'd5, 1'b1, 8'h2D, 1'b0, 16'h0);
    idle(6);

    // T2: WIDTH=4 corners
    send(1'b0, 4'hF, 4'hF, 8'($urandom), 8'($urandom), 4'd6, 1'b1, 8'hE1, 1'b0, 16'h0);
    send(1'b1, 4'h8, 4'h8, 8'($urandom), 8'($urandom), 4'd7, 1'b1, 8'h40, 1'b0, 16'h0);
    send(1'b1, 4'h8, 4'h7, 8'($urandom), 8'($urandom), 4'd8, 1'b1, 8'hC8, 1'b0, 16'h0);
    send(1'b1, 4'hF, 4'h1, 8'($urandom), 8'($urandom), 4'd9, 1'b1, 8'hFF, 1'b0, 16'h0);
    send(1'b0, 4'h0, 4'hB, 8'($urandom), 8'($urandom), 4'd10, 1'b1, 8'h00, 1'b0, 16'h0);
    send(1'b1, 4'h0, 4'h9, 8'($urandom), 8'($urandom), 4'd11, 1'b1, 8'h00, 1'b0, 16'h0);
    idle(6);

    // T3: WIDTH=8 corners back-to-back, tags 1..3
    send(1'b0, 4'($urandom), 4'($urandom), 8'hFF, 8'hFF, 4'd1, 1'b0, 8'h0, 1'b1, 16'hFE01);
    send(1'b1, 4'($urandom), 4'($urandom), 8'h80, 8'h80, 4'd2, 1'b0, 8'h0, 1'b1, 16'h4000);
    send(1'b1, 4'($urandom), 4'($urandom), 8'h80, 8'h7F, 4'd3, 1'b0, 8'h0, 1'b1, 16'hC080);
    idle(6);

    // T4: consumer stalls for 6 cycles while the source keeps streaming
    out_ready = 1'b0;
    stall_win = 1'b1;
    for (int i = 0; i < 6; i++) begin
      randomize_ops();
      in_valid  = 1'b1;
      in_signed = 1'($urandom);
      in_tag    = 4'(i);
      @(posedge clk);
      #1;
    end
    stall_win = 1'b0;
    out_ready = 1'b1;
    idle(10);

    // T5: reset with two ops in flight, then nothing until a new accept
    send(1'b0, 4'd7, 4'd3, 8'd9, 8'd11, 4'd12, 1'b0, 8'h0, 1'b0, 16'h0);
    send(1'b1, 4'd9, 4'd5, 8'd200, 8'd3, 4'd13, 1'b0, 8'h0, 1'b0, 16'h0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);
    send(1'b0, 4'd6, 4'd7, 8'd13, 8'd17, 4'd14, 1'b1, 8'h2A, 1'b1, 16'h00DD);
    idle(6);

    // T6: random operands, signedness, tags, source gaps and consumer stalls
    base  = n_acc;
    guard = 0;
    while (n_acc < base + 10000 && guard < 60000) begin
      randomize_ops();
      in_valid  = $urandom_range(0, 9) < 8;
      in_signed = 1'($urandom);
      in_tag    = 4'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
      guard++;
    end
    out_ready = 1'b1;
    idle(10);

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
